vip_avst_packet_decoder: RTL and testbench
==========================================

Name: vip_avst_packet_decoder

Overview:
Avalon-ST video packet decoder that sits directly upstream of the flow-control input adapter in the clocked-video paths. It classifies incoming packets by the header nibble:
- Control packets (type 0xF) are parsed into width, height and interlaced fields.
- Video payload (type 0x0) is forwarded tagged with is_video and end_of_video.
- All other packets are absorbed.
The downstream adapter consumes dout_* plus the decoder_* field outputs.

Parameters:
BITS_PER_SYMBOL, 8, bits per symbol (must be ≥4).
SYMBOLS_PER_BEAT, 3, symbols per beat; symbol 0 occupies the LSBs.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
din_valid  in  1  upstream beat valid
din_ready  out  1  upstream beat accepted when din_valid & din_ready
din_data  in  BITS_PER_SYMBOL*SYMBOLS_PER_BEAT  upstream beat
din_sop  in  1  start of packet
din_eop  in  1  end of packet
dout_valid  out  1  output beat valid
dout_ready  in  1  downstream accept
dout_data  out  BITS_PER_SYMBOL*SYMBOLS_PER_BEAT  payload beat
decoder_is_video  out  1  dout beat is video payload
decoder_end_of_video  out  1  dout beat is last beat of a video packet
decoder_width  out  16  last committed control-packet width
decoder_height  out  16  last committed control-packet height
decoder_interlaced  out  4  last committed interlace nibble
decoder_vip_ctrl_valid  out  1  level; high once any complete control packet has been committed

Behaviour:
- Reset (rst=0, async):
  - FSM returns to IDLE.
  - dout_valid, dout_data, decoder_is_video, decoder_end_of_video, decoder_vip_ctrl_valid are 0.
  - width, height, interlaced are 0; nibble counter is 0.
- Handshake:
  - Single output register: din_ready = ~dout_valid | dout_ready.
  - A beat is accepted when din_valid & din_ready.
  - Forwarded beats appear on dout the following cycle (latency 1); full throughput is sustained.
  - dout_* hold while dout_valid & ~dout_ready.
- Header handling:
  - Any accepted beat with din_sop is a header; type = din_data[3:0] (symbol 0).
  - Header beats are never forwarded.
  - sop while mid-packet (eop lost) is treated as a new header, i.e. a resync.
- FSM states: IDLE, VIDEO, CTRL, DISCARD.
  - IDLE: accepts and drops non-sop beats. On sop, goes to VIDEO if type 0x0, CTRL if type 0xF, else DISCARD.
  - A header with sop&eop stays in IDLE. It produces no output and no commit.
  - VIDEO: each accepted beat is forwarded with is_video=1; end_of_video = din_eop. On eop, go to IDLE.
  - CTRL:
    - Nibble k (k=0..8) is taken from bits [3:0] of symbol k mod SYMBOLS_PER_BEAT in payload beat k / SYMBOLS_PER_BEAT.
    - Nibble order: width[15:12], [11:8], [7:4], [3:0], then height in the same order, then interlaced.
    - Nibbles are collected into shadow registers. Nibbles beyond 9 are ignored.
    - On eop with ≥9 nibbles received: commit shadow to the decoder_* fields in the same edge and set vip_ctrl_valid.
    - On eop with <9 nibbles: no commit; previous fields are kept.
    - Go to IDLE.
  - DISCARD: accepts and drops beats until eop, then goes to IDLE.
- Field outputs change only at commit, never mid-packet. vip_ctrl_valid is never cleared except by reset.
- Reset asserted mid-packet: the partial control shadow is lost and output beats are dropped. After reset, beats are dropped until the next sop.

Optional Feature:
Macro VIP_DECODER_PASS_USER_EN.
- Defined: packets of types 0x1–0xE are forwarded, including the header beat, with is_video=0 and end_of_video=0, using the same handshake and latency as video beats.
- Undefined: these packets are absorbed in DISCARD with no output.
- Control and video handling are identical in both builds.

Decomposition:
Shared package holds:
- Packet type constants: TYPE_VIDEO=4'h0, TYPE_CTRL=4'hF.
- CTRL_NIBBLES=9.
- FSM state enum.
One sub-module, vip_ctrl_packet_parser: nibble counter, shadow registers, commit logic. The top level holds the FSM and the output register.

Test Plan:
- Control packet, SYMBOLS_PER_BEAT=3, beats in order:
  - header 0x00000F with sop
  - 0x080200, 0x010000
  - 0x00000E with eop
  - -> width 0x0280 (640), height 0x01E0 (480), interlaced 0, vip_ctrl_valid rises the cycle after the eop beat; no dout_valid.
- Video packet of header + 4 payload beats, dout_ready=1 -> 4 dout beats, 1-cycle latency, is_video=1, end_of_video only on beat 4.
- Same video packet, dout_ready toggling 1/0 each cycle -> no beat lost or duplicated; din_ready low exactly when dout_valid & ~dout_ready.
- Short control packet (header + 1 beat with eop) after the 640x480 packet -> fields unchanged, vip_ctrl_valid stays 1.
- Video packet truncated by a new sop of type 0xF -> VIDEO exits with no end_of_video; the control packet parses normally.
- Type 0x3 packet of 3 beats -> no output without the macro; with VIP_DECODER_PASS_USER_EN, 3 beats with is_video=0. Also drive rst low mid-control-packet -> all outputs 0 and the following payload beats are dropped.

Source files
------------

// File: rtl/vip_avst_packet_decoder_pkg.sv
// Shared types for the Avalon-ST video packet decoder.
// Packet type codes, control packet length and decoder FSM states.
package vip_avst_packet_decoder_pkg;

  localparam logic [3:0] TYPE_VIDEO = 4'h0;
  localparam logic [3:0] TYPE_CTRL  = 4'hF;
  localparam int CTRL_NIBBLES = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_VIDEO,
    ST_CTRL,
    ST_DISCARD
  } state_t;

endpackage

// File: rtl/vip_ctrl_packet_parser.sv
// Control packet parser: collects width/height/interlace nibbles
// into a shadow and commits them atomically at a complete packet's eop.
module vip_ctrl_packet_parser
  import vip_avst_packet_decoder_pkg::*;
#(
  parameter int SYMBOLS_PER_BEAT = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          beat_valid,
  input  logic                          beat_eop,
  input  logic [4*SYMBOLS_PER_BEAT-1:0] beat_nibbles,
  output logic [15:0]                   width,
  output logic [15:0]                   height,
  output logic [3:0]                    interlaced,
  output logic                          ctrl_valid
);

  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic [CTRL_NIBBLES-1:0][3:0] shadow;
  logic [CTRL_NIBBLES-1:0][3:0] shadow_nxt;
  int idx;
  int sum;

  always_comb begin
    shadow_nxt = shadow;
    idx = 0;
    for (int j = 0; j < SYMBOLS_PER_BEAT; j++) begin
      idx = int'(cnt) + j;
      if (idx < CTRL_NIBBLES)
        shadow_nxt[idx[3:0]] = beat_nibbles[4*j +: 4];
    end
    sum = int'(cnt) + SYMBOLS_PER_BEAT;
    cnt_nxt = (sum >= CTRL_NIBBLES) ? 4'(CTRL_NIBBLES) : 4'(sum);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      shadow     <= '0;
      width      <= '0;
      height     <= '0;
      interlaced <= '0;
      ctrl_valid <= 1'b0;
    end else if (start) begin
      cnt <= '0;
    end else if (beat_valid) begin
      shadow <= shadow_nxt;
      cnt    <= beat_eop ? 4'd0 : cnt_nxt;
      // Commit uses this beat's nibbles too, so read the next shadow
      if (beat_eop && cnt_nxt == 4'(CTRL_NIBBLES)) begin
        width <= {shadow_nxt[0], shadow_nxt[1],
                  shadow_nxt[2], shadow_nxt[3]};
        height <= {shadow_nxt[4], shadow_nxt[5],
                   shadow_nxt[6], shadow_nxt[7]};
        interlaced <= shadow_nxt[8];
        ctrl_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vip_avst_packet_decoder.sv
// Avalon-ST video packet decoder: header FSM plus one output register.
// VIP_DECODER_PASS_USER_EN forwards user packets (types 0x1-0xE).
module vip_avst_packet_decoder
  import vip_avst_packet_decoder_pkg::*;
#(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      din_valid,
  output logic                                      din_ready,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] din_data,
  input  logic                                      din_sop,
  input  logic                                      din_eop,
  output logic                                      dout_valid,
  input  logic                                      dout_ready,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
  output logic                                      decoder_is_video,
  output logic                                      decoder_end_of_video,
  output logic [15:0]                               decoder_width,
  output logic [15:0]                               decoder_height,
  output logic [3:0]                                decoder_interlaced,
  output logic                                      decoder_vip_ctrl_valid
);

  state_t state;
  state_t state_nxt;
  logic accept;
  logic fwd;
  logic fwd_video;
  logic fwd_eov;
  logic [3:0] hdr_type;
  logic [4*SYMBOLS_PER_BEAT-1:0] nibbles;

  assign din_ready = ~dout_valid | dout_ready;
  assign accept    = din_valid & din_ready;
  assign hdr_type  = din_data[3:0];

  for (genvar g = 0; g < SYMBOLS_PER_BEAT; g++) begin : g_nib
    assign nibbles[4*g +: 4] = din_data[BITS_PER_SYMBOL*g +: 4];
  end

  always_comb begin
    state_nxt = state;
    fwd       = 1'b0;
    fwd_video = 1'b0;
    fwd_eov   = 1'b0;
    if (accept) begin
      // Any sop restarts decoding, even mid-packet
      if (din_sop) begin
        unique case (1'b1)
          hdr_type == TYPE_VIDEO: state_nxt = ST_VIDEO;
          hdr_type == TYPE_CTRL:  state_nxt = ST_CTRL;
          default: begin
            state_nxt = ST_DISCARD;
`ifdef VIP_DECODER_PASS_USER_EN
            fwd = 1'b1;
`endif
          end
        endcase
      end else begin
        unique case (state)
          ST_IDLE: ;
          ST_VIDEO: begin
            fwd       = 1'b1;
            fwd_video = 1'b1;
            fwd_eov   = din_eop;
          end
          ST_CTRL: ;
          ST_DISCARD: begin
`ifdef VIP_DECODER_PASS_USER_EN
            fwd = 1'b1;
`endif
          end
          default: ;
        endcase
      end
      if (din_eop)
        state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= ST_IDLE;
      dout_valid           <= 1'b0;
      dout_data            <= '0;
      decoder_is_video     <= 1'b0;
      decoder_end_of_video <= 1'b0;
    end else begin
      state <= state_nxt;
      if (din_ready) begin
        dout_valid <= fwd;
        if (fwd) begin
          dout_data            <= din_data;
          decoder_is_video     <= fwd_video;
          decoder_end_of_video <= fwd_eov;
        end
      end
    end
  end

  vip_ctrl_packet_parser #(
    .SYMBOLS_PER_BEAT(SYMBOLS_PER_BEAT)
  ) u_parser (
    .clk         (clk),
    .rst         (rst),
    .start       (accept & din_sop),
    .beat_valid  (accept & ~din_sop & (state == ST_CTRL)),
    .beat_eop    (din_eop),
    .beat_nibbles(nibbles),
    .width       (decoder_width),
    .height      (decoder_height),
    .interlaced  (decoder_interlaced),
    .ctrl_valid  (decoder_vip_ctrl_valid)
  );

endmodule

// File: tb/tb_vip_avst_packet_decoder.sv
// Bench for vip_avst_packet_decoder: packet-level model with a
// per-cycle compare process plus literal expectations.
module tb_vip_avst_packet_decoder;

  localparam int B = 8;
  localparam int S = 3;
  localparam int W = B * S;

  logic clk = 1'b0;
  logic rst;
  logic din_valid, din_ready, din_sop, din_eop;
  logic [W-1:0] din_data;
  logic dout_valid, dout_ready;
  logic [W-1:0] dout_data;
  logic decoder_is_video, decoder_end_of_video;
  logic [15:0] decoder_width, decoder_height;
  logic [3:0] decoder_interlaced;
  logic decoder_vip_ctrl_valid;

  always #5 clk = ~clk;

  vip_avst_packet_decoder #(
    .BITS_PER_SYMBOL(B),
    .SYMBOLS_PER_BEAT(S)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .din_valid             (din_valid),
    .din_ready             (din_ready),
    .din_data              (din_data),
    .din_sop               (din_sop),
    .din_eop               (din_eop),
    .dout_valid            (dout_valid),
    .dout_ready            (dout_ready),
    .dout_data             (dout_data),
    .decoder_is_video      (decoder_is_video),
    .decoder_end_of_video  (decoder_end_of_video),
    .decoder_width         (decoder_width),
    .decoder_height        (decoder_height),
    .decoder_interlaced    (decoder_interlaced),
    .decoder_vip_ctrl_valid(decoder_vip_ctrl_valid)
  );

  typedef struct {
    logic [W-1:0] d;
    logic sop;
    logic eop;
  } beat_t;

  typedef struct {
    logic [W-1:0] d;
    logic v;
    logic e;
  } out_t;

  beat_t pkt[$];
  out_t  expq[$];
  logic [15:0] exp_w = '0;
  logic [15:0] exp_h = '0;
  logic [3:0]  exp_i = '0;
  logic        exp_cv = 1'b0;
  int pass_cnt = 0;
  int total = 0;
  int hs_cnt = 0;
  int eov_cnt = 0;
  int rdy_mode = 0;
  int hs0, eov0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Per-cycle compare against the packet-level model
  logic hold_prev = 1'b0;
  logic [W+1:0] prev_out;
  always @(negedge clk) begin
    out_t o;
    if (rst) begin
      chk("din_ready", 64'(din_ready), 64'(!dout_valid || dout_ready));
      if (hold_prev)
        chk("hold", 64'({dout_valid, dout_data, decoder_is_video,
                         decoder_end_of_video}), 64'({1'b1, prev_out}));
      if (dout_valid && dout_ready) begin
        hs_cnt++;
        if (decoder_end_of_video) eov_cnt++;
        chk("beat_expected", 64'(expq.size() != 0), 64'(1));
        if (expq.size() != 0) begin
          o = expq.pop_front();
          chk("dout_beat",
              64'({dout_data, decoder_is_video, decoder_end_of_video}),
              64'({o.d, o.v, o.e}));
        end
      end
      chk("fields",
          64'({decoder_width, decoder_height, decoder_interlaced,
               decoder_vip_ctrl_valid}),
          64'({exp_w, exp_h, exp_i, exp_cv}));
      hold_prev = dout_valid && !dout_ready;
      prev_out = {dout_data, decoder_is_video, decoder_end_of_video};
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic add(input logic [W-1:0] d, input logic s, input logic e);
    beat_t b;
    b.d = d;
    b.sop = s;
    b.eop = e;
    pkt.push_back(b);
  endtask

  // Derive expected outputs of the whole packet from its beats
  task automatic model_pkt(output logic commit, output logic [15:0] w,
                           output logic [15:0] h, output logic [3:0] il);
    logic [3:0] t;
    logic [3:0] nib[$];
    out_t o;
    commit = 1'b0;
    w = exp_w;
    h = exp_h;
    il = exp_i;
    if (pkt.size() == 0 || !pkt[0].sop) return;
    t = pkt[0].d[3:0];
    if (t == 4'h0) begin
      for (int i = 1; i < pkt.size(); i++) begin
        o.d = pkt[i].d;
        o.v = 1'b1;
        o.e = pkt[i].eop;
        expq.push_back(o);
      end
    end else if (t == 4'hF) begin
      for (int i = 1; i < pkt.size(); i++)
        for (int j = 0; j < S; j++)
          nib.push_back(pkt[i].d[B*j +: 4]);
      if (pkt.size() > 1 && pkt[pkt.size()-1].eop && nib.size() >= 9) begin
        commit = 1'b1;
        w = {nib[0], nib[1], nib[2], nib[3]};
        h = {nib[4], nib[5], nib[6], nib[7]};
        il = nib[8];
      end
    end else begin
`ifdef VIP_DECODER_PASS_USER_EN
      for (int i = 0; i < pkt.size(); i++) begin
        o.d = pkt[i].d;
        o.v = 1'b0;
        o.e = 1'b0;
        expq.push_back(o);
      end
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_mode == 1) dout_ready = ~dout_ready;
  endtask

  task automatic drive_beat(input beat_t b);
    logic acc;
    acc = 1'b0;
    din_valid = 1'b1;
    din_data = b.d;
    din_sop = b.sop;
    din_eop = b.eop;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      acc = din_ready;
      tick();
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", 64'(acc), 64'(1));
    din_valid = 1'b0;
    din_sop = 1'b0;
    din_eop = 1'b0;
  endtask

  task automatic send_pkt();
    logic c;
    logic [15:0] w, h;
    logic [3:0] il;
    model_pkt(c, w, h, il);
    for (int i = 0; i < pkt.size(); i++) drive_beat(pkt[i]);
    if (c) begin
      exp_w = w;
      exp_h = h;
      exp_i = il;
      exp_cv = 1'b1;
    end
    pkt.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic c;
    logic [15:0] w, h;
    logic [3:0] il;
    rst = 1'b1;
    din_valid = 1'b0;
    din_data = '0;
    din_sop = 1'b0;
    din_eop = 1'b0;
    dout_ready = 1'b1;
    #2 rst = 1'b0;
    idle(3);
    chk("rst_dout", 64'({dout_valid, dout_data, decoder_is_video,
                         decoder_end_of_video}), 64'(0));
    chk("rst_fields", 64'({decoder_width, decoder_height,
                           decoder_interlaced, decoder_vip_ctrl_valid}),
        64'(0));
    rst = 1'b1;
    idle(2);

    // 640x480 progressive control packet
    hs0 = hs_cnt;
    add(24'h00000F, 1, 0);
    add(24'h080200, 0, 0);
    add(24'h010000, 0, 0);
    add(24'h00000E, 0, 1);
    send_pkt();
    chk("ctrl_valid_rise", 64'(decoder_vip_ctrl_valid), 64'(1));
    chk("ctrl_width", 64'(decoder_width), 64'h0280);
    chk("ctrl_height", 64'(decoder_height), 64'h01E0);
    chk("ctrl_interlaced", 64'(decoder_interlaced), 64'h0);
    idle(2);
    chk("ctrl_no_dout", 64'(hs_cnt - hs0), 64'(0));

    // Video packet, downstream always ready
    hs0 = hs_cnt;
    eov0 = eov_cnt;
    add(24'h000000, 1, 0);
    add(24'h111111, 0, 0);
    add(24'h222222, 0, 0);
    add(24'h333333, 0, 0);
    add(24'h444444, 0, 1);
    model_pkt(c, w, h, il);
    drive_beat(pkt[0]);
    chk("hdr_not_fwd", 64'(dout_valid), 64'(0));
    drive_beat(pkt[1]);
    chk("lat1_valid", 64'(dout_valid), 64'(1));
    chk("lat1_data", 64'(dout_data), 64'h111111);
    chk("lat1_video", 64'({decoder_is_video, decoder_end_of_video}),
        64'(2));
    for (int i = 2; i < 5; i++) drive_beat(pkt[i]);
    pkt.delete();
    idle(2);
    chk("video_beats", 64'(hs_cnt - hs0), 64'(4));
    chk("video_eov", 64'(eov_cnt - eov0), 64'(1));

    // Same packet, downstream ready toggling
    hs0 = hs_cnt;
    eov0 = eov_cnt;
    rdy_mode = 1;
    add(24'h000000, 1, 0);
    add(24'h111111, 0, 0);
    add(24'h222222, 0, 0);
    add(24'h333333, 0, 0);
    add(24'h444444, 0, 1);
    send_pkt();
    idle(6);
    rdy_mode = 0;
    dout_ready = 1'b1;
    idle(2);
    chk("toggle_beats", 64'(hs_cnt - hs0), 64'(4));
    chk("toggle_eov", 64'(eov_cnt - eov0), 64'(1));

    // Short control packet leaves fields alone
    add(24'h00000F, 1, 0);
    add(24'h000001, 0, 1);
    send_pkt();
    idle(2);
    chk("short_width", 64'(decoder_width), 64'h0280);
    chk("short_cv", 64'(decoder_vip_ctrl_valid), 64'(1));

    // Video truncated by a control header (1280x720, interlace 3)
    hs0 = hs_cnt;
    eov0 = eov_cnt;
    add(24'h000000, 1, 0);
    add(24'h555555, 0, 0);
    add(24'h666666, 0, 0);
    send_pkt();
    add(24'h00000F, 1, 0);
    add(24'h000500, 0, 0);
    add(24'h020000, 0, 0);
    add(24'h03000D, 0, 1);
    send_pkt();
    idle(2);
    chk("trunc_beats", 64'(hs_cnt - hs0), 64'(2));
    chk("trunc_eov", 64'(eov_cnt - eov0), 64'(0));
    chk("resync_width", 64'(decoder_width), 64'h0500);
    chk("resync_height", 64'(decoder_height), 64'h02D0);
    chk("resync_il", 64'(decoder_interlaced), 64'h3);

    // User packet type 0x3
    hs0 = hs_cnt;
    add(24'h000003, 1, 0);
    add(24'h123456, 0, 0);
    add(24'hABCDEF, 0, 1);
    send_pkt();
    idle(2);
`ifdef VIP_DECODER_PASS_USER_EN
    chk("user_beats", 64'(hs_cnt - hs0), 64'(3));
`else
    chk("user_beats", 64'(hs_cnt - hs0), 64'(0));
`endif

    // Reset in the middle of a control packet
    add(24'h00000F, 1, 0);
    add(24'h080200, 0, 0);
    send_pkt();
    rst = 1'b0;
    expq.delete();
    exp_w = '0;
    exp_h = '0;
    exp_i = '0;
    exp_cv = 1'b0;
    idle(2);
    chk("mid_rst_out", 64'({dout_valid, decoder_width, decoder_height,
                            decoder_interlaced, decoder_vip_ctrl_valid}),
        64'(0));
    rst = 1'b1;
    idle(1);
    hs0 = hs_cnt;
    add(24'h010000, 0, 0);
    add(24'h00000E, 0, 1);
    add(24'h777777, 0, 1);
    send_pkt();
    idle(2);
    chk("post_rst_drop", 64'(hs_cnt - hs0), 64'(0));
    chk("post_rst_cv", 64'(decoder_vip_ctrl_valid), 64'(0));
    add(24'h00000F, 1, 0);
    add(24'h080200, 0, 0);
    add(24'h010000, 0, 0);
    add(24'h00000E, 0, 1);
    send_pkt();
    idle(2);
    chk("recover_height", 64'(decoder_height), 64'h01E0);

    chk("drain", 64'(expq.size()), 64'(0));
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
